multi_hot_encoder: RTL and testbench

- Parametrised successor to the team's 8-to-3 one-hot encoder.
- Accepts an N-bit request vector with any number of bits set over a valid/ready handshake.
- Emits the binary index of every set bit, one index per accepted output beat, in priority order.
- Sits between request-collection logic (interrupt/status vectors) and downstream index consumers that take one index at a time.

---
 rtl/multi_hot_encoder_pkg.sv | 27 ++
 rtl/multi_hot_encoder_first_set_finder.sv | 21 ++
 rtl/multi_hot_encoder.sv | 96 +++++++++
 tb/tb_multi_hot_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_hot_encoder_pkg.sv
// Shared state type and index helpers for the multi-hot encoder.
// Masks are zero-extended to MAX_N so one search function serves every width.
package multi_hot_encoder_pkg;

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam int MAX_N = 64;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The final matching assignment wins, so the scan direction selects the priority.
  function automatic int first_set(input logic [MAX_N-1:0] mask, input logic msb_first);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (msb_first) begin
        if (mask[i]) r = i;
      end else begin
        if (mask[MAX_N-1-i]) r = MAX_N - 1 - i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_hot_encoder_first_set_finder.sv
// Combinational priority search over the pending mask: returns the next index to
// emit and flags when exactly one bit is left.
module first_set_finder
  import multi_hot_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         single_o
);

  logic [MAX_N-1:0] mask_ext;

  assign mask_ext = MAX_N'(mask_i);
  assign idx_o    = W'(first_set(mask_ext, MSB_FIRST));
  assign single_o = (mask_i != '0) && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/multi_hot_encoder.sv
// Multi-hot to binary-index serialiser: one index per output beat, in priority order.
// Define MULTI_HOT_ENCODER_ONEHOT_CHECK_EN to pulse err_multi on non-one-hot vectors.
module multi_hot_encoder
  import multi_hot_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         zero_in,
  output logic         err_multi
);

  state_t       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic         zero_q, zero_d;
  logic [W-1:0] found_idx;
  logic         single;
  logic         accept;
  logic         emit;

  first_set_finder #(.N(N), .MSB_FIRST(MSB_FIRST)) u_finder (
    .mask_i  (mask_q),
    .idx_o   (found_idx),
    .single_o(single)
  );

  // Outputs are gated by rst so they read zero during the reset cycle itself.
  assign in_ready  = en & ~rst & (state_q == IDLE);
  assign out_valid = en & ~rst & (state_q == DRAIN);
  assign out_last  = ~rst & (state_q == DRAIN) & single;
  assign idx       = rst ? '0 : found_idx;
  assign zero_in   = zero_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d = din;
          zero_d = (din == '0);
          if (din != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (emit) begin
          mask_d = mask_q & ~(N'(1) << found_idx);
          if (single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

`ifdef MULTI_HOT_ENCODER_ONEHOT_CHECK_EN
  logic err_q, err_d;

  assign err_d = accept & ((din & (din - N'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_multi = err_q & ~rst;
`else
  assign err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_multi_hot_encoder.sv
// Scoreboard bench: LSB-first and MSB-first encoders share stimulus; the model keeps
// a queue of pending indices per instance and checks every cycle at the falling edge.
module tb_multi_hot_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;

  logic       in_ready0, out_valid0, out_last0, zero0, err0;
  logic       in_ready1, out_valid1, out_last1, zero1, err1;
  logic [2:0] idx0, idx1;

  logic rand_mode = 1'b0;
  logic force_en = 1'b1;
  logic force_ready = 1'b1;

  int q0[$];
  int q1[$];
  logic zero_pend = 1'b0;
  logic err_pend = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  multi_hot_encoder #(.N(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
    .in_ready(in_ready0), .idx(idx0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .zero_in(zero0), .err_multi(err0)
  );

  multi_hot_encoder #(.N(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
    .in_ready(in_ready1), .idx(idx1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .zero_in(zero1), .err_multi(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Handshake knobs: random back-pressure and enable gaps, or directed values.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
    end else begin
      out_ready = force_ready;
      en        = force_en;
    end
  end

  // Monitor: compare against the model's current state, then apply this cycle's
  // accept/pop so the model steps together with the coming rising edge.
  always @(negedge clk) begin
    logic exp_rdy, exp_val;
    if (rst) begin
      chk("rst_in_ready0", in_ready0, 0);
      chk("rst_out_valid0", out_valid0, 0);
      chk("rst_idx0", idx0, 0);
      chk("rst_out_last0", out_last0, 0);
      chk("rst_zero0", zero0, 0);
      chk("rst_err0", err0, 0);
      chk("rst_out_valid1", out_valid1, 0);
      chk("rst_out_last1", out_last1, 0);
      q0.delete();
      q1.delete();
      zero_pend = 1'b0;
      err_pend  = 1'b0;
    end else begin
      exp_rdy = en && (q0.size() == 0);
      exp_val = en && (q0.size() != 0);
      chk("zero_in0", zero0, zero_pend);
      chk("zero_in1", zero1, zero_pend);
      chk("err_multi0", err0, err_pend);
      chk("err_multi1", err1, err_pend);
      chk("in_ready0", in_ready0, exp_rdy);
      chk("in_ready1", in_ready1, exp_rdy);
      chk("out_valid0", out_valid0, exp_val);
      chk("out_valid1", out_valid1, exp_val);
      if (exp_val) begin
        chk("idx0", idx0, q0[0]);
        chk("out_last0", out_last0, q0.size() == 1);
        chk("idx1", idx1, q1[0]);
        chk("out_last1", out_last1, q1.size() == 1);
      end
      zero_pend = 1'b0;
      err_pend  = 1'b0;
      if (in_valid && exp_rdy) begin
        for (int i = 0; i < 8; i++) if (din[i]) q0.push_back(i);
        for (int i = 7; i >= 0; i--) if (din[i]) q1.push_back(i);
        zero_pend = (din == 8'h00);
`ifdef MULTI_HOT_ENCODER_ONEHOT_CHECK_EN
        err_pend = ($countones(din) > 1);
`endif
      end
      if (exp_val && out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int cyc;
    cyc = 0;
    @(posedge clk);
    #1;
    din = v;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready0 && !rst) break;
      cyc++;
      if (cyc > 300) begin
        timeout_fail("send_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_beat();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid0 && out_ready) break;
      cyc++;
      if (cyc > 300) begin
        timeout_fail("wait_beat");
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !in_valid) break;
      cyc++;
      if (cyc > 1000) begin
        timeout_fail("wait_idle");
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'b0010_0101);
    wait_idle();

    send(8'b0010_0101);
    wait_beat();
    force_ready = 1'b0;
    repeat (3) @(posedge clk);
    force_ready = 1'b1;
    wait_idle();

    send(8'hFF);
    wait_idle();

    send(8'h00);
    wait_idle();

    send(8'b1000_0011);
    wait_beat();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h10);
    wait_idle();

    send(8'h40);
    wait_idle();
    send(8'h41);
    wait_idle();

    send(8'hF0);
    wait_beat();
    force_en = 1'b0;
    repeat (4) @(posedge clk);
    force_en = 1'b1;
    wait_idle();

    rand_mode = 1'b1;
    for (int k = 0; k < 150; k++) begin
      logic [7:0] v;
      case ($urandom_range(0, 5))
        0:       v = 8'h00;
        1:       v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      send(v);
    end
    rand_mode = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
